beh_reset_rx: RTL and testbench

Receive-side companion to the behavioural staged reset/start generator. It samples the asynchronous `reset_n` vector (reset lanes first, then start lanes) into the `clk` domain and enforces the release order: all resets, then a minimum gap, then starts. It produces synchronized per-lane reset and start-enable outputs plus phase status for the csp2verilog runtime of one clock domain.

---
 rtl/beh_reset_rx.sv | 164 ++++++++++++++++
 tb/tb_beh_reset_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/beh_reset_rx.sv
// beh_reset_rx: synchronizes staged reset/start lanes and enforces reset -> gap -> start release order.
// Optional protocol checking is compiled in by defining CAST2VERILOG_RESET_CHECK_EN.
module beh_reset_rx #(
  parameter int RESETS      = 1,
  parameter int STARTS      = 0,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_GAP     = 4,
  parameter int CNT_W       = 16,
  localparam int GW         = (STARTS > 0) ? STARTS : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RESETS+STARTS-1:0] reset_n_in,
  output logic [RESETS-1:0]        reset_n_out,
  output logic [GW-1:0]            go,
  output logic                     resets_done,
  output logic                     started,
  output logic [CNT_W-1:0]         gap_count,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam int NL = RESETS + STARTS;
  localparam logic [CNT_W-1:0] GAP_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GAP_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] gap_count_r;
  logic [NL-1:0]    sync_r [SYNC_STAGES];
  logic [NL-1:0]    lane_s;
  logic [RESETS-1:0] res_s;
  logic [GW-1:0]    start_s;
  logic             start_all_s;
  logic             res_all_s;
  logic             gap_met_s;
  logic             go_en_s;
  logic [1:0]       chk_code_s;

  // Per-lane synchronizer chain; reset loads the asserted (low) level
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {NL{1'b0}};
      end
    end else begin
      sync_r[0] <= reset_n_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign lane_s    = sync_r[SYNC_STAGES-1];
  assign res_s     = lane_s[RESETS-1:0];
  assign res_all_s = &res_s;
  assign gap_met_s = (64'(gap_count_r) >= 64'(MIN_GAP));

  if (STARTS > 0) begin : g_start
    assign start_s     = lane_s[NL-1:RESETS];
    assign start_all_s = &start_s;
  end else begin : g_nostart
    assign start_s     = {GW{1'b0}};
    assign start_all_s = 1'b1;
  end

`ifdef CAST2VERILOG_RESET_CHECK_EN
  logic       start_any_s;
  logic       start_low_s;
  logic [1:0] err_code_r;

  assign start_any_s = |start_s;
  assign start_low_s = (STARTS > 0) && !start_all_s;

  // Protocol violation detect; each state can raise only its own cause
  always_comb begin
    chk_code_s = 2'd0;
    case (state_r)
      ST_RESET: begin
        if (start_any_s) chk_code_s = 2'd1;
        else             chk_code_s = 2'd0;
      end
      ST_WAIT: begin
        if (start_any_s && !gap_met_s) chk_code_s = 2'd2;
        else                           chk_code_s = 2'd0;
      end
      ST_RUN: begin
        if (start_low_s && res_all_s) chk_code_s = 2'd3;
        else                          chk_code_s = 2'd0;
      end
      default: chk_code_s = 2'd0;
    endcase
  end

  // First error cause; ERR is sticky so the latched code cannot be overwritten
  always_ff @(posedge clk) begin
    if (reset) begin
      err_code_r <= 2'd0;
    end else if ((state_r != ST_ERR) && (chk_code_s != 2'd0)) begin
      err_code_r <= chk_code_s;
    end else begin
      err_code_r <= err_code_r;
    end
  end

  assign err      = (state_r == ST_ERR);
  assign err_code = err_code_r;
`else
  assign chk_code_s = 2'd0;
  assign err        = 1'b0;
  assign err_code   = 2'd0;
`endif

  // Release sequencer; an error in the same cycle as a reset-lane drop wins
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RESET;
      gap_count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_RESET: begin
          if (chk_code_s != 2'd0) state_r <= ST_ERR;
          else if (res_all_s)     state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (chk_code_s != 2'd0) begin
            state_r <= ST_ERR;
          end else if (!res_all_s) begin
            state_r     <= ST_RESET;
            gap_count_r <= {CNT_W{1'b0}};
          end else begin
            if (gap_count_r != GAP_MAX) gap_count_r <= gap_count_r + GAP_ONE;
            if (gap_met_s && start_all_s) state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (chk_code_s != 2'd0) begin
            state_r <= ST_ERR;
          end else if (!res_all_s) begin
            state_r     <= ST_RESET;
            gap_count_r <= {CNT_W{1'b0}};
          end
        end
        ST_ERR:  state_r <= ST_ERR;
        default: state_r <= ST_RESET;
      endcase
    end
  end

  // A start lane may be honoured alone once the gap is met, ahead of its siblings
  assign go_en_s     = (state_r == ST_RUN) || ((state_r == ST_WAIT) && gap_met_s);
  assign go          = go_en_s ? start_s : {GW{1'b0}};
  assign reset_n_out = (state_r == ST_ERR) ? {RESETS{1'b0}} : res_s;
  assign resets_done = (state_r == ST_WAIT) || (state_r == ST_RUN);
  assign started     = (state_r == ST_RUN);
  assign gap_count   = gap_count_r;

endmodule

// File: tb/tb_beh_reset_rx.sv
// Bench for beh_reset_rx: two configurations, directed scenarios with literal checks, then random lane activity
// compared every cycle against a phase-level model of the release rules.
`timescale 1ns/1ps
module tb_beh_reset_rx;

  localparam int A_RES = 1, A_ST = 0, A_SYNC = 2, A_GAP = 4, A_CW = 16;
  localparam int B_RES = 2, B_ST = 2, B_SYNC = 2, B_GAP = 4, B_CW = 3;
`ifdef CAST2VERILOG_RESET_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [0:0] in_a = 1'b0;
  logic [3:0] in_b = 4'b0000;

  logic [0:0]  rno_a, go_a;
  logic        done_a, start_a, err_a;
  logic [15:0] gap_a;
  logic [1:0]  ec_a;
  logic [1:0]  rno_b, go_b;
  logic        done_b, start_b, err_b;
  logic [2:0]  gap_b;
  logic [1:0]  ec_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit model_on = 1'b0;

  beh_reset_rx #(.RESETS(A_RES), .STARTS(A_ST), .SYNC_STAGES(A_SYNC), .MIN_GAP(A_GAP), .CNT_W(A_CW)) dut_a (
    .clk(clk), .reset(reset), .reset_n_in(in_a), .reset_n_out(rno_a), .go(go_a),
    .resets_done(done_a), .started(start_a), .gap_count(gap_a), .err(err_a), .err_code(ec_a));

  beh_reset_rx #(.RESETS(B_RES), .STARTS(B_ST), .SYNC_STAGES(B_SYNC), .MIN_GAP(B_GAP), .CNT_W(B_CW)) dut_b (
    .clk(clk), .reset(reset), .reset_n_in(in_b), .reset_n_out(rno_b), .go(go_b),
    .resets_done(done_b), .started(start_b), .gap_count(gap_b), .err(err_b), .err_code(ec_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: lane history, whether resets are released, whether running, cycles waited, fault cause
  typedef struct packed {
    logic            released;
    logic            running;
    logic [1:0]      fault;
    int              gap;
    logic [3:0][3:0] pipe;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] din, input logic rst,
                                    input int nres, input int nst, input int mgap, input int gmax, input int stages);
    mdl_t n;
    logic [3:0] s, rmask, smask;
    bit all_res, any_st, all_st;
    logic [1:0] code;
    n = m;
    if (rst) begin
      n = '0;
      return n;
    end
    rmask = 4'((1 << nres) - 1);
    smask = 4'(((1 << nst) - 1) << nres);
    s = m.pipe[stages-1];
    for (int k = 3; k > 0; k--) n.pipe[k] = m.pipe[k-1];
    n.pipe[0] = din;
    if (m.fault != 2'd0) return n;
    all_res = ((s & rmask) == rmask);
    any_st  = ((s & smask) != 4'd0);
    all_st  = ((s & smask) == smask);
    code = 2'd0;
    if (CHK) begin
      if (!m.released && any_st) code = 2'd1;
      else if (m.released && !m.running && any_st && m.gap < mgap) code = 2'd2;
      else if (m.running && !all_st && all_res) code = 2'd3;
    end
    if (code != 2'd0) begin
      n.fault = code;
    end else if (!all_res) begin
      n.released = 1'b0;
      n.running  = 1'b0;
      n.gap      = 0;
    end else if (!m.released) begin
      n.released = 1'b1;
    end else if (!m.running) begin
      if (m.gap >= mgap && all_st) n.running = 1'b1;
      if (m.gap < gmax) n.gap = m.gap + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = mdl_step(ma, {3'b000, in_a}, reset, A_RES, A_ST, A_GAP, (1 << A_CW) - 1, A_SYNC);
    mb = mdl_step(mb, in_b, reset, B_RES, B_ST, B_GAP, (1 << B_CW) - 1, B_SYNC);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_one(input string tag, input mdl_t m, input int nres, input int nst, input int mgap,
                             input int stages, input logic [31:0] rno, input logic [31:0] g, input logic [31:0] rd,
                             input logic [31:0] st, input logic [31:0] gp, input logic [31:0] er, input logic [31:0] ec);
    logic [3:0] s;
    logic [31:0] rmask, e_rno, e_go;
    bit fl, en;
    s = m.pipe[stages-1];
    rmask = (32'd1 << nres) - 32'd1;
    fl = (m.fault != 2'd0);
    e_rno = fl ? 32'd0 : (32'(s) & rmask);
    en = !fl && (m.running || (m.released && m.gap >= mgap));
    e_go = (en && nst > 0) ? ((32'(s) >> nres) & ((32'd1 << nst) - 32'd1)) : 32'd0;
    check({tag, "_reset_n_out"}, rno, e_rno);
    check({tag, "_go"}, g, e_go);
    check({tag, "_resets_done"}, rd, 32'(m.released && !fl));
    check({tag, "_started"}, st, 32'(m.running && !fl));
    check({tag, "_gap_count"}, gp, 32'(m.gap));
    check({tag, "_err"}, er, 32'(fl));
    check({tag, "_err_code"}, ec, 32'(m.fault));
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (model_on) begin
      compare_one("a", ma, A_RES, A_ST, A_GAP, A_SYNC, 32'(rno_a), 32'(go_a), 32'(done_a), 32'(start_a),
                  32'(gap_a), 32'(err_a), 32'(ec_a));
      compare_one("b", mb, B_RES, B_ST, B_GAP, B_SYNC, 32'(rno_b), 32'(go_b), 32'(done_b), 32'(start_b),
                  32'(gap_b), 32'(err_b), 32'(ec_b));
    end
  end

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    model_on = 1'b1;
    to_cyc(2);
    check("rst_b_reset_n_out", 32'(rno_b), 32'd0);
    check("rst_b_go", 32'(go_b), 32'd0);
    check("rst_b_resets_done", 32'(done_b), 32'd0);
    check("rst_b_started", 32'(start_b), 32'd0);
    check("rst_b_gap_count", 32'(gap_b), 32'd0);
    check("rst_b_err", 32'(err_b), 32'd0);
    check("rst_b_err_code", 32'(ec_b), 32'd0);
    reset = 1'b0;

    // Basic release: A has no start lanes, B starts released later
    to_cyc(10);
    in_a = 1'b1;
    in_b = 4'b0011;
    to_cyc(11); check("a_rno_c11", 32'(rno_a), 32'd0);
    to_cyc(12); check("a_rno_c12", 32'(rno_a), 32'd1); check("a_done_c12", 32'(done_a), 32'd0);
    to_cyc(13); check("a_done_c13", 32'(done_a), 32'd1); check("b_done_c13", 32'(done_b), 32'd1);
    to_cyc(17); check("a_started_c17", 32'(start_a), 32'd0);
    to_cyc(18); check("a_started_c18", 32'(start_a), 32'd1); check("a_gap_c18", 32'(gap_a), 32'd5);
    to_cyc(30); check("b_gap_sat_c30", 32'(gap_b), 32'd7); check("b_started_c30", 32'(start_b), 32'd0);
    in_b = 4'b1111;
    to_cyc(31); check("b_go_c31", 32'(go_b), 32'd0);
    to_cyc(32); check("b_go_c32", 32'(go_b), 32'd3); check("b_err_c32", 32'(err_b), 32'd0);
    to_cyc(33); check("b_started_c33", 32'(start_b), 32'd1);

    // Re-reset: reset lane 1 low for 5 cycles (starts withdrawn with it)
    to_cyc(40); in_b = 4'b0001;
    to_cyc(42); check("b_started_c42", 32'(start_b), 32'd1);
    to_cyc(43);
    check("b_started_c43", 32'(start_b), 32'd0);
    check("b_go_c43", 32'(go_b), 32'd0);
    check("b_gap_c43", 32'(gap_b), 32'd0);
    check("b_done_c43", 32'(done_b), 32'd0);
    to_cyc(45); in_b = 4'b0011;
    to_cyc(48); check("b_done_c48", 32'(done_b), 32'd1);
    to_cyc(55); in_b = 4'b1111;
    to_cyc(56); check("b_go_c56", 32'(go_b), 32'd0);
    to_cyc(57); check("b_go_c57", 32'(go_b), 32'd3);
    to_cyc(58); check("b_started_c58", 32'(start_b), 32'd1); check("b_err_c58", 32'(err_b), 32'd0);

    // Starts released ahead of resets
    to_cyc(60); reset = 1'b1; in_b = 4'b0000;
    to_cyc(61); reset = 1'b0;
    check("b_rno_c61", 32'(rno_b), 32'd0); check("b_started_c61", 32'(start_b), 32'd0);
    check("a_started_c61", 32'(start_a), 32'd0); check("a_gap_c61", 32'(gap_a), 32'd0);
    to_cyc(62); in_b = 4'b1100;
    to_cyc(65); check("b_err_c65", 32'(err_b), 32'(CHK)); check("b_err_code_c65", 32'(ec_b), CHK ? 32'd1 : 32'd0);
    to_cyc(66); in_b = 4'b1111;
    to_cyc(70); check("b_rno_c70", 32'(rno_b), CHK ? 32'd0 : 32'd3);
    to_cyc(72); check("b_go_c72", 32'(go_b), 32'd0);
    to_cyc(73); check("b_go_c73", 32'(go_b), CHK ? 32'd0 : 32'd3);
    to_cyc(74);
    check("b_started_c74", 32'(start_b), CHK ? 32'd0 : 32'd1);
    check("b_err_c74", 32'(err_b), 32'(CHK));

    // Local reset while running
    to_cyc(80); check("a_started_c80", 32'(start_a), 32'd1); reset = 1'b1;
    to_cyc(81);
    reset = 1'b0;
    check("a_rno_c81", 32'(rno_a), 32'd0); check("a_started_c81", 32'(start_a), 32'd0);
    check("a_done_c81", 32'(done_a), 32'd0); check("a_gap_c81", 32'(gap_a), 32'd0);
    check("b_go_c81", 32'(go_b), 32'd0); check("b_started_c81", 32'(start_b), 32'd0);
    check("b_err_c81", 32'(err_b), 32'd0); check("b_err_code_c81", 32'(ec_b), 32'd0);

    // Random lane activity with occasional local resets
    while (cyc < 3000) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) in_a = ~in_a;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, (i < 2) ? 39 : 24) == 0) in_b[i] = ~in_b[i];
      end
    end
    reset = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
